// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage, instruction memory and the IF/ID consumer.
// Purely structural, so it adds no latency.
// No flow control of its own: hold/flush arrive on the fetch stage's plain ports.
interface fetch_stage_if;
    logic [11:0] address_imem;    // instruction memory address (current PC)
    logic [31:0] q_imem;          // instruction word at address_imem, same cycle
    logic [31:0] ifid_insn;       // latched instruction toward decode
    logic [11:0] ifid_pc_next;    // PC+1 of the latched instruction
    logic        ifid_valid;      // 0 = bubble
    logic        ifid_predicted;  // latched instruction caused a fetch-time redirect

    // Fetch-stage side: drives the address and the IF/ID latch, receives the word.
    modport master (
        output address_imem,
        output ifid_insn,
        output ifid_pc_next,
        output ifid_valid,
        output ifid_predicted,
        input  q_imem
    );

    // Memory / decode side: supplies the word, observes the address and the latch.
    modport slave (
        input  address_imem,
        input  ifid_insn,
        input  ifid_pc_next,
        input  ifid_valid,
        input  ifid_predicted,
        output q_imem
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem address, latches the word into IF/ID.
// One cycle from address_imem=A to the word at A on ifid_insn; redirect costs one bubble.
// stall holds PC and IF/ID; redirect_valid overrides stall and flushes IF/ID.
// Optional FETCH_JUMP_PREDICT_EN: redirect at fetch time on 'j' (opcode 5'b00001).
module fetch_stage #(
    parameter logic [11:0] RESET_PC = 12'd0,
    parameter logic [31:0] NOP_WORD = 32'd0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [11:0]  redirect_target,
    fetch_stage_if.master bus
);

    // Program counter and IF/ID latch state.
    logic [11:0] pc_q,      pc_d;
    logic [31:0] insn_q,    insn_d;
    logic [11:0] pc_next_q, pc_next_d;
    logic        valid_q,   valid_d;

    // Sequential successor; 12-bit arithmetic wraps FFF -> 000 silently.
    logic [11:0] pc_plus1;
    assign pc_plus1 = pc_q + 12'd1;

`ifdef FETCH_JUMP_PREDICT_EN
    logic pred_q, pred_d;
    logic is_jump;

    // 'j' is recognised from the opcode alone; its target is the low 12 bits.
    assign is_jump = (bus.q_imem[31:27] == 5'b00001);
`endif

    // Next-state selection: redirect > stall > (fetch-time jump) > PC+1.
    always_comb begin
        pc_d      = pc_q;
        insn_d    = insn_q;
        pc_next_d = pc_next_q;
        valid_d   = valid_q;
`ifdef FETCH_JUMP_PREDICT_EN
        pred_d    = pred_q;
`endif
        if (redirect_valid) begin
            // Flush: the word currently on q_imem is on the wrong path.
            pc_d      = redirect_target;
            insn_d    = NOP_WORD;
            pc_next_d = 12'd0;
            valid_d   = 1'b0;
`ifdef FETCH_JUMP_PREDICT_EN
            pred_d    = 1'b0;
`endif
        end else if (!stall) begin
            insn_d    = bus.q_imem;
            pc_next_d = pc_plus1;
            valid_d   = 1'b1;
`ifdef FETCH_JUMP_PREDICT_EN
            if (is_jump) begin
                // Tag the jump so decode does not redirect a second time.
                pc_d   = bus.q_imem[11:0];
                pred_d = 1'b1;
            end else begin
                pc_d   = pc_plus1;
                pred_d = 1'b0;
            end
`else
            pc_d      = pc_plus1;
`endif
        end
    end

    // State registers with synchronous reset overriding every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            insn_q    <= NOP_WORD;
            pc_next_q <= 12'd0;
            valid_q   <= 1'b0;
`ifdef FETCH_JUMP_PREDICT_EN
            pred_q    <= 1'b0;
`endif
        end else begin
            pc_q      <= pc_d;
            insn_q    <= insn_d;
            pc_next_q <= pc_next_d;
            valid_q   <= valid_d;
`ifdef FETCH_JUMP_PREDICT_EN
            pred_q    <= pred_d;
`endif
        end
    end

    // Outputs come straight from registers; address_imem is the PC itself.
    assign bus.address_imem = pc_q;
    assign bus.ifid_insn    = insn_q;
    assign bus.ifid_pc_next = pc_next_q;
    assign bus.ifid_valid   = valid_q;
`ifdef FETCH_JUMP_PREDICT_EN
    assign bus.ifid_predicted = pred_q;
`else
    assign bus.ifid_predicted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage with a queue-based scoreboard.
// The driver pushes the state expected after each rising edge; the monitor pops and compares.
// Expectations for the jump case follow FETCH_JUMP_PREDICT_EN.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [11:0] redirect_target;

    fetch_stage_if ifc ();

    fetch_stage #(
        .RESET_PC (12'd0),
        .NOP_WORD (32'd0)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .bus             (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [31:0] JWORD = 32'h0800_0040;

    // Instruction memory model: address-tagged words, one 'j 0x40' at 0x100.
    function automatic logic [31:0] word(input logic [11:0] a);
        if (a == 12'h100) return JWORD;
        return {20'hC0DE0, a};
    endfunction

    assign ifc.q_imem = word(ifc.address_imem);

    typedef struct {
        logic [11:0] addr;
        logic [31:0] insn;
        logic [11:0] pcn;
        logic        vld;
        logic        pred;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    // Drive inputs for the next rising edge and record the resulting state.
    task automatic step(input logic rst, input logic stl, input logic rv, input logic [11:0] tgt,
                        input logic [11:0] ea, input logic [31:0] ei, input logic [11:0] ep,
                        input logic ev, input logic epr);
        exp_t x;
        @(negedge clock);
        reset           = rst;
        stall           = stl;
        redirect_valid  = rv;
        redirect_target = tgt;
        x.addr = ea; x.insn = ei; x.pcn = ep; x.vld = ev; x.pred = epr;
        exp_q.push_back(x);
    endtask

    // Monitor: sample one time unit after each rising edge.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ifc.address_imem !== e.addr || ifc.ifid_insn !== e.insn ||
                ifc.ifid_pc_next !== e.pcn || ifc.ifid_valid !== e.vld ||
                ifc.ifid_predicted !== e.pred) begin
                errors++;
                $display("FAIL step%0d got addr=%h insn=%h pcn=%h vld=%b pred=%b want addr=%h insn=%h pcn=%h vld=%b pred=%b",
                         checks, ifc.address_imem, ifc.ifid_insn, ifc.ifid_pc_next,
                         ifc.ifid_valid, ifc.ifid_predicted,
                         e.addr, e.insn, e.pcn, e.vld, e.pred);
            end
        end
    end

`ifdef FETCH_JUMP_PREDICT_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 12'd0;

        // Reset state.
        step(1, 0, 0, 12'h000, 12'h000, 32'h0,        12'h000, 0, 0);
        // Free run from reset: addresses 1..5, words lag by one cycle.
        step(0, 0, 0, 12'h000, 12'h001, word(12'h000), 12'h001, 1, 0);
        step(0, 0, 0, 12'h000, 12'h002, word(12'h001), 12'h002, 1, 0);
        step(0, 0, 0, 12'h000, 12'h003, word(12'h002), 12'h003, 1, 0);
        step(0, 0, 0, 12'h000, 12'h004, word(12'h003), 12'h004, 1, 0);
        step(0, 0, 0, 12'h000, 12'h005, word(12'h004), 12'h005, 1, 0);
        // Stall three cycles at PC=5: everything holds.
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 12'h000, 12'h005, word(12'h004), 12'h005, 1, 0);
        step(0, 0, 0, 12'h000, 12'h006, word(12'h005), 12'h006, 1, 0);
        step(0, 0, 0, 12'h000, 12'h007, word(12'h006), 12'h007, 1, 0);
        step(0, 0, 0, 12'h000, 12'h008, word(12'h007), 12'h008, 1, 0);
        step(0, 0, 0, 12'h000, 12'h009, word(12'h008), 12'h009, 1, 0);
        step(0, 0, 0, 12'h000, 12'h00A, word(12'h009), 12'h00A, 1, 0);
        // Redirect together with stall at PC=10: redirect wins, bubble inserted.
        step(0, 1, 1, 12'h080, 12'h080, 32'h0,         12'h000, 0, 0);
        step(0, 0, 0, 12'h000, 12'h081, word(12'h080), 12'h081, 1, 0);
        // Wrap-around through FFF.
        step(0, 0, 1, 12'hFFE, 12'hFFE, 32'h0,         12'h000, 0, 0);
        step(0, 0, 0, 12'h000, 12'hFFF, word(12'hFFE), 12'hFFF, 1, 0);
        step(0, 0, 0, 12'h000, 12'h000, word(12'hFFF), 12'h000, 1, 0);
        step(0, 0, 0, 12'h000, 12'h001, word(12'h000), 12'h001, 1, 0);
        // Reset beats stall and redirect.
        step(1, 1, 1, 12'h055, 12'h000, 32'h0,         12'h000, 0, 0);
        step(0, 0, 0, 12'h000, 12'h001, word(12'h000), 12'h001, 1, 0);
        // Jump word at 0x100.
        step(0, 0, 1, 12'h100, 12'h100, 32'h0,         12'h000, 0, 0);
        if (PRED) begin
            step(0, 0, 0, 12'h000, 12'h040, JWORD,         12'h101, 1, 1);
            step(0, 0, 0, 12'h000, 12'h041, word(12'h040), 12'h041, 1, 0);
        end else begin
            step(0, 0, 0, 12'h000, 12'h101, JWORD,         12'h101, 1, 0);
            step(0, 0, 0, 12'h000, 12'h102, word(12'h101), 12'h102, 1, 0);
        end
        // Stall while the jump word is on q_imem: no fetch-time redirect, bubble holds.
        step(0, 0, 1, 12'h100, 12'h100, 32'h0,         12'h000, 0, 0);
        step(0, 1, 0, 12'h000, 12'h100, 32'h0,         12'h000, 0, 0);
        // Downstream redirect beats the jump word.
        step(0, 0, 1, 12'h200, 12'h200, 32'h0,         12'h000, 0, 0);
        step(0, 0, 0, 12'h000, 12'h201, word(12'h200), 12'h201, 1, 0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        @(negedge clock);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
